bf16_result_packer: RTL and testbench

//  Output stage after the normalize stage. Takes the fp32 results that normalize produces, one per

---
 rtl/bf16_result_packer.sv | 163 ++++++++++++++++
 tb/tb_bf16_result_packer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_result_packer.sv
// bf16_result_packer: rounds fp32 results to bf16 (round-to-nearest-even), packs four per
// 64-bit word and streams the words out of a small FIFO, framed by a result count.
module bf16_result_packer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [63:0]      out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0]       lane_q, lane_d;
  logic [47:0]      asm_q, asm_d;
  logic [63:0]      mem_q [DEPTH];
  logic [63:0]      mem_d [DEPTH];
  logic [DEPTH-1:0] last_q, last_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic        fifo_full;
  logic        accept;
  logic        pop;
  logic        push;
  logic        last_in;
  logic [31:0] rnd_sum;
  logic [15:0] rnd_unused;
  logic [15:0] bf;
  logic [5:0]  shamt;
  logic [63:0] word;

  assign fifo_full = (cnt_q == (AW+1)'(DEPTH));
  assign in_ready  = (state_q == S_RUN) && !fifo_full;
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 64'h0;
  assign out_last  = out_valid & last_q[rd_ptr_q];
  assign busy      = busy_q;
  assign done      = done_q;

  assign accept  = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign last_in = (rem_q == LEN_W'(1));
  assign push    = accept && ((lane_q == 2'd3) || last_in);

  // Adding 0x7FFF plus the bf16 lsb rounds to nearest with ties going to the even value.
  assign rnd_sum    = in_data + 32'h0000_7FFF + {31'd0, in_data[16]};
  assign rnd_unused = rnd_sum[15:0];
  assign bf         = (in_data[30:23] == 8'd0) ? 16'h0000 : rnd_sum[31:16];

  // Lanes above the current one in asm_q are always zero, so OR-ing in the new lane is safe.
  assign shamt = {lane_q, 4'd0};
  assign word  = {16'h0, asm_q} | ({48'h0, bf} << shamt);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    lane_d   = lane_q;
    asm_d    = asm_q;
    mem_d    = mem_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = S_RUN;
            rem_d   = len;
            lane_d  = 2'd0;
            asm_d   = 48'h0;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          rem_d = rem_q - LEN_W'(1);
          if (push) begin
            lane_d = 2'd0;
            asm_d  = 48'h0;
          end else begin
            lane_d = lane_q + 2'd1;
            asm_d  = word[47:0];
          end
          if (last_in) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q]  = word;
      last_d[wr_ptr_q] = last_in;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      lane_q   <= 2'd0;
      asm_q    <= 48'h0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 64'h0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      lane_q   <= lane_d;
      asm_q    <= asm_d;
      mem_q    <= mem_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_bf16_result_packer.sv
// Self-checking bench for bf16_result_packer: scenario tasks against a queue-based
// reference model that rounds with plain integer arithmetic and groups results by four.
module tb_bf16_result_packer;
  localparam int DEPTH = 4;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [63:0]      out_data;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             done;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, last_hs_cyc = -1;
  int or_mode = 1;
  bit tmo = 0;
  logic [63:0] rx_data[$];
  bit          rx_last[$];
  logic [63:0] exp_data[$];
  bit          exp_last[$];
  logic [31:0] stim[$];

  bf16_result_packer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // out_ready policy: 0 = held low, 1 = held high, 2 = random per cycle
  initial forever begin
    @(posedge clk); #1;
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_last.push_back(out_last);
      if (out_last) last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [15:0] ref_bf16(input logic [31:0] x);
    int unsigned hi, lo;
    if (x[30:23] == 8'd0) return 16'h0000;
    hi = x >> 16;
    lo = x & 32'hFFFF;
    if (lo > 32'h8000 || (lo == 32'h8000 && hi % 2 == 1)) hi++;
    return hi[15:0];
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] x;
    x = $urandom;
    if ($urandom_range(0, 7) == 0) x[30:23] = 8'h00;
    if (x[30:23] == 8'hFF) x[30:23] = 8'hFE;
    if ($urandom_range(0, 3) == 0) x[15:0] = 16'h8000;
    return x;
  endfunction

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(rand_fp());
  endtask

  task automatic build_exp(input int n);
    logic [63:0] w;
    exp_data.delete();
    exp_last.delete();
    for (int i = 0; i < n; i += 4) begin
      w = 64'h0;
      for (int k = 0; k < 4 && i + k < n; k++) w[16*k +: 16] = ref_bf16(stim[i+k]);
      exp_data.push_back(w);
      exp_last.push_back(i + 4 >= n);
    end
  endtask

  task automatic set_or(input int m);
    or_mode = m;
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int from, input int to, input bit gaps);
    int  b;
    bit  ok;
    tmo = 0;
    for (int i = from; i < to; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = stim[i];
      b = 0;
      ok = 0;
      while (!ok && b < 500) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        b++;
      end
      if (!ok) tmo = 1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy && b < 3000) begin
      @(posedge clk); #1;
      b++;
    end
    if (busy) tmo = 1;
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({in_ready, out_valid, out_last, busy, done} !== 5'b0)
      $display("FAIL reset_ctrl got rdy/ov/last/busy/done=%b exp 00000", {in_ready, out_valid, out_last, busy, done});
    else n_pass++;
    n_chk++;
    if (out_data !== 64'h0) $display("FAIL reset_data got %h exp 0", out_data);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int d0;
    set_or(1);
    stim = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h00000000};
    rx_data.delete(); rx_last.delete();
    d0 = done_cnt;
    start_frame(4);
    n_chk++;
    if (busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", busy); else n_pass++;
    send(0, 4, 0);
    n_chk++;
    if ({out_valid, out_last} !== 2'b11) $display("FAIL basic_latency got valid/last=%b exp 11", {out_valid, out_last});
    else n_pass++;
    wait_idle();
    n_chk++;
    if (rx_data.size() != 1 || tmo) $display("FAIL basic_count got %0d exp 1 (tmo=%0d)", rx_data.size(), tmo);
    else n_pass++;
    n_chk++;
    if (rx_data[0] !== 64'h0000_BF80_4000_3F80 || rx_last[0] !== 1'b1)
      $display("FAIL basic_word got %h last %0d exp 0000bf8040003f80 last 1", rx_data[0], rx_last[0]);
    else n_pass++;
    n_chk++;
    if (done_cnt != d0 + 1 || done_cyc != last_hs_cyc + 1)
      $display("FAIL basic_done got cnt %0d cyc %0d exp cnt %0d cyc %0d", done_cnt - d0, done_cyc, 1, last_hs_cyc + 1);
    else n_pass++;
  endtask

  task automatic test_rounding();
    stim = '{32'h3F808000, 32'h3F818000, 32'h3F807FFF, 32'h7F7FFFFF, 32'h00400000};
    rx_data.delete(); rx_last.delete();
    start_frame(5);
    send(0, 5, 0);
    wait_idle();
    n_chk++;
    if (rx_data.size() != 2) $display("FAIL round_count got %0d exp 2", rx_data.size());
    else n_pass++;
    n_chk++;
    if (rx_data[0] !== 64'h7F80_3F80_3F82_3F80 || rx_last[0] !== 1'b0)
      $display("FAIL round_word0 got %h last %0d exp 7f803f803f823f80 last 0", rx_data[0], rx_last[0]);
    else n_pass++;
    n_chk++;
    if (rx_data[1] !== 64'h0 || rx_last[1] !== 1'b1)
      $display("FAIL round_word1 got %h last %0d exp 0 last 1", rx_data[1], rx_last[1]);
    else n_pass++;
  endtask

  task automatic test_stream();
    int d0;
    fill_random(6);
    build_exp(6);
    rx_data.delete(); rx_last.delete();
    d0 = done_cnt;
    start_frame(6);
    send(0, 6, 0);
    wait_idle();
    n_chk++;
    if (rx_data.size() != 2 || done_cnt != d0 + 1)
      $display("FAIL stream_count got words %0d dones %0d exp 2 1", rx_data.size(), done_cnt - d0);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (rx_data[i] !== exp_data[i] || rx_last[i] !== exp_last[i])
        $display("FAIL stream_word%0d got %h last %0d exp %h last %0d", i, rx_data[i], rx_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
    n_chk++;
    if (rx_data[1][63:32] !== 32'h0) $display("FAIL stream_pad got %h exp 0", rx_data[1][63:32]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc, bad;
    bit ok;
    logic [63:0] held;
    set_or(0);
    fill_random(32);
    build_exp(32);
    rx_data.delete(); rx_last.delete();
    start_frame(32);
    acc = 0;
    in_valid = 1'b1;
    repeat (30) begin
      in_data = stim[acc];
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) acc++;
    end
    n_chk++;
    if (acc != 4 * DEPTH || in_ready !== 1'b0)
      $display("FAIL bp_stall got accepted %0d in_ready %b exp %0d 0", acc, in_ready, 4 * DEPTH);
    else n_pass++;
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== exp_data[0])
      $display("FAIL bp_head got valid %b data %h exp 1 %h", out_valid, out_data, exp_data[0]);
    else n_pass++;
    held = out_data;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (out_data !== held || out_last !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL bp_stable got %h last %b exp %h last 0", out_data, out_last, held);
    else n_pass++;
    or_mode = 1;
    send(acc, 32, 0);
    wait_idle();
    n_chk++;
    if (rx_data.size() != 8 || tmo) $display("FAIL bp_count got %0d exp 8 (tmo=%0d)", rx_data.size(), tmo);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 8 && i < rx_data.size(); i++)
      if (rx_data[i] !== exp_data[i] || rx_last[i] !== exp_last[i]) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL bp_order got %0d bad words exp 0", bad);
    else n_pass++;
  endtask

  task automatic test_len0_and_restart();
    int d0, seen;
    set_or(1);
    rx_data.delete(); rx_last.delete();
    d0 = done_cnt;
    start_frame(0);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL len0_done got done %b busy %b exp 1 0", done, busy);
    else n_pass++;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid || done) seen++;
    end
    n_chk++;
    if (seen != 0 || rx_data.size() != 0 || done_cnt != d0 + 1)
      $display("FAIL len0_quiet got extra %0d words %0d dones %0d exp 0 0 1", seen, rx_data.size(), done_cnt - d0);
    else n_pass++;

    fill_random(8);
    build_exp(8);
    d0 = done_cnt;
    start_frame(8);
    send(0, 4, 0);
    start = 1'b1;
    len   = LEN_W'(3);
    @(posedge clk); #1;
    start = 1'b0;
    send(4, 8, 0);
    wait_idle();
    n_chk++;
    if (rx_data.size() != 2 || done_cnt != d0 + 1)
      $display("FAIL restart_count got words %0d dones %0d exp 2 1", rx_data.size(), done_cnt - d0);
    else n_pass++;
    n_chk++;
    if (rx_data[0] !== exp_data[0] || rx_data[1] !== exp_data[1] || rx_last[1] !== 1'b1)
      $display("FAIL restart_words got %h %h exp %h %h", rx_data[0], rx_data[1], exp_data[0], exp_data[1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d0;
    set_or(0);
    fill_random(16);
    rx_data.delete(); rx_last.delete();
    start_frame(16);
    send(0, 8, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, busy, in_ready} !== 3'b000)
      $display("FAIL rstmid_async got valid/busy/rdy=%b exp 000", {out_valid, busy, in_ready});
    else n_pass++;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++;
    if (done_cnt != d0 || rx_data.size() != 0 || out_valid !== 1'b0)
      $display("FAIL rstmid_drop got dones %0d words %0d valid %b exp 0 0 0", done_cnt - d0, rx_data.size(), out_valid);
    else n_pass++;

    set_or(1);
    fill_random(4);
    build_exp(4);
    d0 = done_cnt;
    start_frame(4);
    send(0, 4, 0);
    wait_idle();
    n_chk++;
    if (rx_data.size() != 1 || rx_data[0] !== exp_data[0] || rx_last[0] !== 1'b1 || done_cnt != d0 + 1)
      $display("FAIL rstmid_clean got %0d words %h dones %0d exp 1 %h 1", rx_data.size(), rx_data[0], done_cnt - d0, exp_data[0]);
    else n_pass++;
  endtask

  task automatic test_random_frames();
    int n, d0, bad;
    for (int f = 0; f < 8; f++) begin
      set_or(2);
      n = $urandom_range(1, 20);
      fill_random(n);
      build_exp(n);
      rx_data.delete(); rx_last.delete();
      d0 = done_cnt;
      start_frame(n);
      send(0, n, 1);
      wait_idle();
      bad = 0;
      for (int i = 0; i < exp_data.size() && i < rx_data.size(); i++)
        if (rx_data[i] !== exp_data[i] || rx_last[i] !== exp_last[i]) bad++;
      n_chk++;
      if (tmo || bad != 0 || rx_data.size() != exp_data.size() || done_cnt != d0 + 1)
        $display("FAIL rand_frame%0d len %0d got words %0d bad %0d dones %0d tmo %0d exp words %0d bad 0 dones 1",
                 f, n, rx_data.size(), bad, done_cnt - d0, tmo, exp_data.size());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_stream();
    test_backpressure();
    test_len0_and_restart();
    test_reset_mid();
    test_random_frames();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
